// File: rtl/avalon_st_udp_tx_pkg.sv
// Shared types and protocol constants for the UDP/IPv4/Ethernet frame builder.
//   state_t    : frame builder FSM states
//   constants  : EtherType, IPv4 version/IHL, TOS, flags/fragment, TTL,
//                protocol number and header lengths
//   csum_fold  : folds a wide ones'-complement sum down to 16 bits
package avalon_st_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_TOS        = 8'h00;
  localparam logic [15:0] IP_FLAGS_FRAG = 16'h4000;
  localparam logic [7:0]  IP_TTL        = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;

  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int HDR_LEN     = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam int FCS_LEN     = 4;

  // Ten 16-bit words sum to less than 2^20; two folds always absorb every carry.
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] s1;
    logic [16:0] s2;
    s1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
    return s2[15:0];
  endfunction

endpackage

// File: rtl/avalon_st_udp_tx_if.sv
// Multi-lane Avalon-ST source bus carrying the finished frame.
//   tx_data  : lane i occupies bits [i*LANE_BYTES*8 +: LANE_BYTES*8]
//   tx_empty : per-lane empty byte count, EW bits per lane
//   tx_sof/tx_eof/tx_valid/tx_er : per-lane flags
//   ready    : sink ready, ready latency 0
// master = frame source, slave = frame sink.
interface avalon_st_udp_tx_if #(
  parameter int LANES      = 4,
  parameter int LANE_BYTES = 16
);
  localparam int EW = $clog2(LANE_BYTES);

  logic [LANES*LANE_BYTES*8-1:0] tx_data;
  logic [LANES*EW-1:0]           tx_empty;
  logic [LANES-1:0]              tx_sof;
  logic [LANES-1:0]              tx_eof;
  logic [LANES-1:0]              tx_valid;
  logic [LANES-1:0]              tx_er;
  logic                          ready;

  modport master (
    output tx_data, tx_empty, tx_sof, tx_eof, tx_valid, tx_er,
    input  ready
  );

  modport slave (
    input  tx_data, tx_empty, tx_sof, tx_eof, tx_valid, tx_er,
    output ready
  );
endinterface

// File: rtl/avalon_st_udp_tx_csum.sv
// IPv4 header checksum, purely combinational.
//   words : the ten 16-bit header words with the checksum word set to zero
//   csum  : ones'-complement of the folded ones'-complement sum
module ipv4_csum
  import avalon_st_pkg::*;
(
  input  logic [9:0][15:0] words,
  output logic [15:0]      csum
);

  logic [19:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) sum = sum + 20'(words[i]);
  end

  assign csum = ~csum_fold(sum);

endmodule

// File: rtl/avalon_st_udp_tx.sv
// Collects NUM_WORDS payload words, wraps them in Ethernet/IPv4/UDP headers
// plus a fixed FCS_VALUE trailer, and streams the frame over a multi-lane Avalon-ST bus.
//   clk, rst          : clock, async active-high reset
//   s_data/s_valid/s_ready : payload word handshake (ready only in IDLE/FILL)
//   dst_mac .. ip_id  : header fields, captured with payload word 0
//   tx                : Avalon-ST source (master modport)
module avalon_st_udp_tx
  import avalon_st_pkg::*;
#(
  parameter int          LANES      = 4,
  parameter int          LANE_BYTES = 16,
  parameter int          NUM_WORDS  = 4,
  parameter logic [31:0] FCS_VALUE  = 32'hABCDEF12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES*LANE_BYTES*8-1:0] s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [47:0]                   dst_mac,
  input  logic [47:0]                   src_mac,
  input  logic [31:0]                   src_ip,
  input  logic [31:0]                   dst_ip,
  input  logic [15:0]                   src_port,
  input  logic [15:0]                   dst_port,
  input  logic [15:0]                   ip_id,
  avalon_st_udp_tx_if.master            tx
);

  localparam int W          = LANES * LANE_BYTES;
  localparam int EW         = $clog2(LANE_BYTES);
  localparam int P          = NUM_WORDS * W;
  localparam int F          = HDR_LEN + P + FCS_LEN;
  localparam int B          = (F + W - 1) / W;
  localparam int FW         = 8 * B * W;
  localparam int EOF_LANE   = ((F - 1) % W) / LANE_BYTES;
  localparam int LAST_EMPTY = LANE_BYTES - 1 - ((F - 1) % LANE_BYTES);
  localparam int BCW        = (B > 1) ? $clog2(B) : 1;
  localparam int WCW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [BCW-1:0] LAST_BEAT  = BCW'(B - 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(NUM_WORDS - 1);
  localparam logic [15:0]    IP_TOT_LEN = 16'(IP_HDR_LEN + UDP_HDR_LEN + P);
  localparam logic [15:0]    UDP_LEN    = 16'(UDP_HDR_LEN + P);

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic [BCW-1:0] beat;
  logic [8*W-1:0] payload [NUM_WORDS];

  logic [47:0] dst_mac_q, src_mac_q;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q, ip_id_q, csum_q;

  logic accept, cap;
  assign accept = s_valid & s_ready;
  assign cap    = accept && (state == IDLE);

  // The "_n" view is what the header/payload registers hold after this edge,
  // so beat 0 can be loaded on the same edge that accepts the last word.
  logic [47:0] dst_mac_n, src_mac_n;
  logic [31:0] src_ip_n, dst_ip_n;
  logic [15:0] src_port_n, dst_port_n, ip_id_n, csum_n, csum_calc;

  assign dst_mac_n  = cap ? dst_mac  : dst_mac_q;
  assign src_mac_n  = cap ? src_mac  : src_mac_q;
  assign src_ip_n   = cap ? src_ip   : src_ip_q;
  assign dst_ip_n   = cap ? dst_ip   : dst_ip_q;
  assign src_port_n = cap ? src_port : src_port_q;
  assign dst_port_n = cap ? dst_port : dst_port_q;
  assign ip_id_n    = cap ? ip_id    : ip_id_q;
  assign csum_n     = cap ? csum_calc : csum_q;

  ipv4_csum u_csum (
    .words ({dst_ip[15:0], dst_ip[31:16], src_ip[15:0], src_ip[31:16], 16'h0000,
             {IP_TTL, IP_PROTO_UDP}, IP_FLAGS_FRAG, ip_id, IP_TOT_LEN, {IP_VER_IHL, IP_TOS}}),
    .csum  (csum_calc)
  );

  logic [8*HDR_LEN-1:0] hdr_be, hdr_le;
  logic [8*P-1:0]       pay_flat_n;
  logic [FW-1:0]        frame;

  assign hdr_be = {dst_mac_n, src_mac_n, ETH_TYPE_IPV4,
                   IP_VER_IHL, IP_TOS, IP_TOT_LEN, ip_id_n, IP_FLAGS_FRAG,
                   IP_TTL, IP_PROTO_UDP, csum_n, src_ip_n, dst_ip_n,
                   src_port_n, dst_port_n, UDP_LEN, 16'h0000};

  // Frame byte n lives at frame[8n +: 8]; that ordering makes a beat a plain slice.
  always_comb begin
    hdr_le = '0;
    for (int i = 0; i < HDR_LEN; i++)
      hdr_le[8*i +: 8] = hdr_be[8*(HDR_LEN-1-i) +: 8];
  end

  always_comb begin
    pay_flat_n = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      pay_flat_n[i*8*W +: 8*W] = (accept && wcnt == WCW'(i)) ? s_data : payload[i];
  end

  assign frame = FW'({FCS_VALUE, pay_flat_n, hdr_le});

  logic [BCW-1:0]       load_beat;
  logic [8*W-1:0]       bt_data;
  logic [LANES-1:0]     bt_valid, bt_sof, bt_eof;
  logic [LANES*EW-1:0]  bt_empty;

  assign load_beat = (state == SEND && beat != LAST_BEAT) ? beat + 1'b1 : '0;
  assign bt_data   = frame[int'(load_beat) * (8*W) +: 8*W];

  always_comb begin
    bt_valid = '1;
    bt_sof   = '0;
    bt_eof   = '0;
    bt_empty = '0;
    if (load_beat == '0) bt_sof[0] = 1'b1;
    if (load_beat == LAST_BEAT) begin
      bt_eof[EOF_LANE]              = 1'b1;
      bt_empty[EOF_LANE*EW +: EW]   = EW'(LAST_EMPTY);
      for (int l = EOF_LANE + 1; l < LANES; l++) begin
        bt_valid[l]        = 1'b0;
        bt_empty[l*EW +: EW] = '1;
      end
    end
  end

  assign tx.tx_er = '0;

  // Payload storage is pure datapath; a partial frame is dropped via the FSM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WORDS; i++)
      if (accept && wcnt == WCW'(i)) payload[i] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      wcnt        <= '0;
      beat        <= '0;
      dst_mac_q   <= '0;
      src_mac_q   <= '0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      ip_id_q     <= '0;
      csum_q      <= '0;
      tx.tx_data  <= '0;
      tx.tx_valid <= '0;
      tx.tx_sof   <= '0;
      tx.tx_eof   <= '0;
      tx.tx_empty <= '1;
    end else begin
      case (state)
        IDLE, FILL: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (state == IDLE) begin
              dst_mac_q  <= dst_mac_n;
              src_mac_q  <= src_mac_n;
              src_ip_q   <= src_ip_n;
              dst_ip_q   <= dst_ip_n;
              src_port_q <= src_port_n;
              dst_port_q <= dst_port_n;
              ip_id_q    <= ip_id_n;
              csum_q     <= csum_n;
            end
            if (wcnt == LAST_WORD) begin
              state       <= SEND;
              s_ready     <= 1'b0;
              wcnt        <= '0;
              beat        <= '0;
              tx.tx_data  <= bt_data;
              tx.tx_valid <= bt_valid;
              tx.tx_sof   <= bt_sof;
              tx.tx_eof   <= bt_eof;
              tx.tx_empty <= bt_empty;
            end else begin
              state <= FILL;
              wcnt  <= wcnt + 1'b1;
            end
          end
        end
        SEND: begin
          if (tx.ready) begin
            if (beat == LAST_BEAT) begin
              state       <= IDLE;
              s_ready     <= 1'b1;
              beat        <= '0;
              tx.tx_valid <= '0;
              tx.tx_sof   <= '0;
              tx.tx_eof   <= '0;
              tx.tx_empty <= '1;
            end else begin
              beat        <= load_beat;
              tx.tx_data  <= bt_data;
              tx.tx_valid <= bt_valid;
              tx.tx_sof   <= bt_sof;
              tx.tx_eof   <= bt_eof;
              tx.tx_empty <= bt_empty;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_udp_tx.sv
module tb_avalon_st_udp_tx;

  localparam int F1 = 302;
  localparam int B1 = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [511:0] s_data;
  logic         s_valid, s_ready;
  logic [127:0] s_data2;
  logic         s_valid2, s_ready2;
  logic [47:0]  dst_mac, src_mac;
  logic [31:0]  src_ip, dst_ip;
  logic [15:0]  src_port, dst_port, ip_id;

  avalon_st_udp_tx_if #(.LANES(4), .LANE_BYTES(16)) tx_if ();
  avalon_st_udp_tx_if #(.LANES(2), .LANE_BYTES(8))  tx_if2 ();

  avalon_st_udp_tx dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip), .dst_ip(dst_ip),
    .src_port(src_port), .dst_port(dst_port), .ip_id(ip_id), .tx(tx_if)
  );

  avalon_st_udp_tx #(.LANES(2), .LANE_BYTES(8), .NUM_WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip), .dst_ip(dst_ip),
    .src_port(src_port), .dst_port(dst_port), .ip_id(ip_id), .tx(tx_if2)
  );

  typedef struct {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] id;
    int          rmode;
    int          gmode;
    logic [15:0] csum;
  } vec_t;

  vec_t         vt [4];
  logic [7:0]   exp_b [F1];
  logic [511:0] pay [4];
  int           pos;
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_b[pos] = v[8*(n-1-i) +: 8];
      pos++;
    end
  endtask

  task automatic set_frame(input int tag, input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] id, input logic [15:0] cs);
    logic [31:0] fcs;
    fcs      = 32'hABCDEF12;
    dst_mac  = 48'h0011_2233_4400 | 48'(tag);
    src_mac  = 48'hA0B1_C2D3_E400 | 48'(tag);
    src_ip   = sip;
    dst_ip   = dip;
    ip_id    = id;
    src_port = 16'h1000 + 16'(tag);
    dst_port = 16'h2000 + 16'(tag);
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 16; i++) pay[w][32*i +: 32] = $urandom();
    pos = 0;
    put(dst_mac, 6); put(src_mac, 6); put(64'h0800, 2);
    put(64'h45, 1); put(64'h00, 1); put(64'd284, 2); put(id, 2); put(64'h4000, 2);
    put(64'd64, 1); put(64'd17, 1); put(cs, 2); put(sip, 4); put(dip, 4);
    put(src_port, 2); put(dst_port, 2); put(64'd264, 2); put(64'h0, 2);
    for (int k = 0; k < 256; k++) begin
      exp_b[pos] = pay[k/64][8*(k%64) +: 8];
      pos++;
    end
    for (int j = 0; j < 4; j++) begin
      exp_b[pos] = fcs[8*j +: 8];
      pos++;
    end
  endtask

  task automatic feed(input int gmode);
    int w;
    int cyc;
    w = 0;
    cyc = 0;
    while (w < 4 && cyc < 200) begin
      @(negedge clk);
      s_valid = !(gmode != 0 && cyc % 3 == 1);
      s_data  = s_valid ? pay[w] : {16{$urandom()}};
      if (s_valid && s_ready) w++;
      cyc++;
    end
    if (w < 4) chk("feed timeout", 512'(w), 512'd4);
  endtask

  task automatic check_beat(input int fi, input int bi);
    logic [511:0] ed, mask;
    logic [3:0]   ev, es, ee;
    logic [15:0]  em;
    int           n, first;
    ed = '0; mask = '0; ev = '0; es = '0; ee = '0; em = '0;
    for (int j = 0; j < 64; j++) begin
      n = bi * 64 + j;
      if (n < F1) begin
        ed[8*j +: 8]   = exp_b[n];
        mask[8*j +: 8] = 8'hFF;
      end
    end
    for (int l = 0; l < 4; l++) begin
      first = bi * 64 + l * 16;
      if (first < F1) begin
        ev[l] = 1'b1;
        if (F1 - 1 < first + 16) begin
          ee[l]        = 1'b1;
          em[4*l +: 4] = 4'(first + 15 - (F1 - 1));
        end
      end else begin
        em[4*l +: 4] = 4'hF;
      end
    end
    es[0] = (bi == 0);
    chk($sformatf("data f%0d b%0d", fi, bi), tx_if.tx_data & mask, ed);
    chk($sformatf("flags f%0d b%0d", fi, bi),
        {tx_if.tx_valid, tx_if.tx_sof, tx_if.tx_eof, tx_if.tx_er, tx_if.tx_empty},
        {ev, es, ee, 4'b0000, em});
  endtask

  task automatic run_vec(input int vi);
    int          bi, c;
    bit          held, sr_bad, rdy;
    logic [543:0] snap, cur;
    set_frame(vi, vt[vi].sip, vt[vi].dip, vt[vi].id, vt[vi].csum);
    feed(vt[vi].gmode);
    bi = 0; c = 0; held = 0; sr_bad = 0; snap = '0;
    while (bi < B1 && c < 200) begin
      @(negedge clk);
      s_valid = 1'b0;
      case (vt[vi].rmode)
        1:       rdy = (c % 4 == 0) || (c % 4 == 3);
        2:       rdy = (c % 3 != 2);
        default: rdy = 1'b1;
      endcase
      tx_if.ready = rdy;
      if (tx_if.tx_valid != 0) begin
        if (s_ready) sr_bad = 1'b1;
        cur = {tx_if.tx_valid, tx_if.tx_sof, tx_if.tx_eof, tx_if.tx_er, tx_if.tx_empty, tx_if.tx_data};
        if (held) chk($sformatf("hold f%0d b%0d", vi, bi), cur, snap);
        if (rdy) begin
          if (bi == 0)
            chk($sformatf("csum f%0d", vi), {tx_if.tx_data[199:192], tx_if.tx_data[207:200]}, vt[vi].csum);
          check_beat(vi, bi);
          bi++;
          held = 1'b0;
        end else begin
          snap = cur;
          held = 1'b1;
        end
      end
      c++;
    end
    if (bi < B1) chk($sformatf("beat timeout f%0d", vi), 512'(bi), 512'(B1));
    chk($sformatf("s_ready in send f%0d", vi), 512'(sr_bad), 512'd0);
    @(negedge clk);
    chk($sformatf("idle after eof f%0d", vi), {tx_if.tx_valid, tx_if.tx_eof, s_ready}, {4'b0, 4'b0, 1'b1});
  endtask

  initial begin
    int          w, c, beats, xfers;
    bit          saw_eof;
    logic [1:0]  eof2, val2;
    logic [5:0]  emp2;

    vt[0] = '{32'hc010fe01, 32'hc0a20d2d, 16'h0000, 0, 0, 16'hADEF};
    vt[1] = '{32'hc010fe01, 32'hc0a20d2d, 16'h0001, 1, 0, 16'hADEE};
    vt[2] = '{32'h0a000001, 32'h0a000002, 16'h1234, 0, 1, 16'h139B};
    vt[3] = '{32'hffffffff, 32'hffffffff, 16'hffff, 2, 1, 16'h39D2};

    rst = 1'b1;
    s_data = '0; s_valid = 1'b0; s_data2 = '0; s_valid2 = 1'b0;
    dst_mac = '0; src_mac = '0; src_ip = '0; dst_ip = '0;
    src_port = '0; dst_port = '0; ip_id = '0;
    tx_if.ready = 1'b0; tx_if2.ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst s_ready", 512'(s_ready), 512'd0);
    chk("rst flags", {tx_if.tx_valid, tx_if.tx_sof, tx_if.tx_eof, tx_if.tx_empty},
        {4'b0, 4'b0, 4'b0, 16'hFFFF});
    chk("rst data", tx_if.tx_data, 512'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready after rst", 512'(s_ready), 512'd1);

    // Narrow configuration: 2 lanes x 8 bytes, 2 words, F = 78.
    src_ip = 32'hc010fe01; dst_ip = 32'hc0a20d2d; ip_id = 16'h0000;
    tx_if2.ready = 1'b1;
    w = 0; c = 0;
    while (w < 2 && c < 50) begin
      @(negedge clk);
      s_data2  = {4{$urandom()}};
      s_valid2 = 1'b1;
      if (s_ready2) w++;
      c++;
    end
    beats = 0; eof2 = '0; val2 = '0; emp2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s_valid2 = 1'b0;
      if (tx_if2.tx_valid != 0) begin
        if (beats == 0) chk("n2 sof", 512'(tx_if2.tx_sof), 512'd1);
        if (beats == 1) chk("n2 csum", {tx_if2.tx_data[71:64], tx_if2.tx_data[79:72]}, 512'h AECF);
        if (tx_if2.tx_eof != 0) begin
          eof2 = tx_if2.tx_eof; val2 = tx_if2.tx_valid; emp2 = tx_if2.tx_empty;
        end
        beats++;
      end
    end
    chk("n2 beats", 512'(beats), 512'd5);
    chk("n2 eof lane", 512'(eof2), 512'h2);
    chk("n2 final valid", 512'(val2), 512'h3);
    chk("n2 final empty", 512'(emp2), 512'h10);

    run_vec(0);
    run_vec(1);

    // Reset while beat 2 is on the bus.
    set_frame(9, 32'h01020304, 32'h05060708, 16'h0055, 16'h0000);
    feed(0);
    tx_if.ready = 1'b1;
    xfers = 0; saw_eof = 0; c = 0;
    while (c < 50) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (tx_if.tx_eof != 0) saw_eof = 1'b1;
      if (tx_if.tx_valid != 0 && xfers == 2) break;
      if (tx_if.tx_valid != 0) xfers++;
      c++;
    end
    chk("reached beat 2", 512'(xfers), 512'd2);
    rst = 1'b1;
    #1;
    chk("rst mid-send flags", {tx_if.tx_valid, tx_if.tx_eof, tx_if.tx_sof}, 512'd0);
    chk("no eof before rst", 512'(saw_eof), 512'd0);
    @(negedge clk);
    chk("rst mid-send s_ready", 512'(s_ready), 512'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("s_ready after mid rst", 512'(s_ready), 512'd1);

    run_vec(2);
    run_vec(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
